// File: rtl/uart_16550_regbank.sv
// uart_16550_regbank: NUM_CH independent 16550 register sets behind one byte-wide host port
module uart_16550_regbank #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [CH_W-1:0]      ch_sel,
    input  logic [2:0]           addr,
    input  logic [7:0]           wr_data,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    input  logic [NUM_CH-1:0]    rx_valid,
    input  logic [8*NUM_CH-1:0]  rx_data,
    input  logic [NUM_CH-1:0]    rx_perr,
    input  logic [NUM_CH-1:0]    rx_ferr,
    input  logic [NUM_CH-1:0]    rx_break,
    input  logic [NUM_CH-1:0]    tx_empty,
    input  logic [NUM_CH-1:0]    thr_empty,
    input  logic [NUM_CH-1:0]    cts_i,
    input  logic [NUM_CH-1:0]    dsr_i,
    input  logic [NUM_CH-1:0]    ri_i,
    input  logic [NUM_CH-1:0]    cd_i,
    output logic [NUM_CH-1:0]    thr_wr,
    output logic [7:0]           thr_data,
    output logic [NUM_CH-1:0]    rx_pop,
    output logic [16*NUM_CH-1:0] divisor,
    output logic [8*NUM_CH-1:0]  lcr_o,
    output logic [8*NUM_CH-1:0]  mcr_o,
    output logic [8*NUM_CH-1:0]  fcr_o,
    output logic [NUM_CH-1:0]    irq,
    output logic                 irq_any
);
    // one read slot per encodable channel; unpopulated slots read as zero
    localparam int SLOTS = 1 << CH_W;
    logic [8*SLOTS-1:0] rv;
    logic [NUM_CH-1:0]  thr_hit;
    logic               rd_any;
    // a write in the same cycle wins and the read is dropped
    assign rd_any  = rd_en & ~wr_en;
    assign irq_any = |irq;
    for (genvar c = 0; c < SLOTS; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            logic [7:0] lcr, dll, dlm, psd, ier, mcr, fcr, spr, rhr, rval, lsr, msr;
            logic [3:0] m, pm, dm, isr_lo;
            logic       sel, ch_wr, ch_rd, dlab, pop, load, lsr_rd, msr_rd, isr_rd;
            logic       dr, oe, pe, fe, bi, dcts, ddsr, teri, dcd;
            logic       thre_p, te_prev, ier_up, thre_clr, ls, rdi, th, ms;
            logic       pop_r, thw_r, irq_r;
            assign sel      = ch_sel == CH_W'(c);
            assign ch_wr    = wr_en & sel;
            assign ch_rd    = rd_any & sel;
            assign dlab     = lcr[7];
            assign pop      = ch_rd & (addr == 3'd0) & ~dlab & dr;
            assign load     = rx_valid[c] & (~dr | pop);
            assign lsr_rd   = ch_rd & (addr == 3'd5) & ~dlab;
            assign msr_rd   = ch_rd & (addr == 3'd6);
            assign isr_rd   = ch_rd & (addr == 3'd2);
            assign thr_hit[c] = ch_wr & (addr == 3'd0) & ~dlab;
            assign ier_up   = ch_wr & (addr == 3'd1) & ~dlab & wr_data[1] & ~ier[1] & thr_empty[c];
            // modem view {cd, ri, dsr, cts}; loopback routes out2/out1/dtr/rts back in
            assign m        = mcr[4] ? {mcr[3], mcr[2], mcr[0], mcr[1]} : {cd_i[c], ri_i[c], dsr_i[c], cts_i[c]};
            assign dm       = m ^ pm;
            assign ls       = ier[2] & (oe | pe | fe | bi);
            assign rdi      = ier[0] & dr;
            assign th       = ier[1] & thre_p;
            assign ms       = ier[3] & (dcts | ddsr | teri | dcd);
            assign isr_lo   = ls ? 4'h6 : rdi ? 4'h4 : th ? 4'h2 : ms ? 4'h0 : 4'h1;
            assign thre_clr = isr_rd & (isr_lo == 4'h2);
            assign lsr      = {1'b0, tx_empty[c], thr_empty[c], bi, fe, pe, oe, dr};
            assign msr      = {m, dcd, teri, ddsr, dcts};
            assign rv[8*c +: 8]       = rval;
            assign divisor[16*c +: 16] = {dlm, dll};
            assign lcr_o[8*c +: 8]     = lcr;
            assign mcr_o[8*c +: 8]     = mcr;
            assign fcr_o[8*c +: 8]     = fcr;
            assign rx_pop[c]           = pop_r;
            assign thr_wr[c]           = thw_r;
            assign irq[c]              = irq_r;
            // host read map with DLAB banking
            always_comb begin
                case (addr)
                    3'd0:    rval = dlab ? dll : rhr;
                    3'd1:    rval = dlab ? dlm : ier;
                    3'd2:    rval = {fcr[0], fcr[0], 2'b00, isr_lo};
                    3'd3:    rval = lcr;
                    3'd4:    rval = mcr;
                    3'd5:    rval = dlab ? psd : lsr;
                    3'd6:    rval = msr;
                    default: rval = spr;
                endcase
            end
            // channel registers, sticky status, THRE tracking and registered pulses
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lcr <= 8'h03; dll <= 8'h01; dlm <= '0; psd <= '0; ier <= '0;
                    mcr <= '0; fcr <= '0; spr <= '0; rhr <= '0; pm <= '0;
                    dr <= 1'b0; oe <= 1'b0; pe <= 1'b0; fe <= 1'b0; bi <= 1'b0;
                    dcts <= 1'b0; ddsr <= 1'b0; teri <= 1'b0; dcd <= 1'b0;
                    thre_p <= 1'b0; te_prev <= 1'b0;
                    pop_r <= 1'b0; thw_r <= 1'b0; irq_r <= 1'b0;
                end else begin
                    if (ch_wr & (addr == 3'd0) & dlab) dll <= wr_data;
                    if (ch_wr & (addr == 3'd1) & dlab) dlm <= wr_data;
                    if (ch_wr & (addr == 3'd1) & ~dlab) ier <= wr_data;
                    fcr <= (ch_wr & (addr == 3'd2)) ? wr_data : {fcr[7:3], 2'b00, fcr[0]};
                    if (ch_wr & (addr == 3'd3)) lcr <= wr_data;
                    if (ch_wr & (addr == 3'd4)) mcr <= wr_data;
                    if (ch_wr & (addr == 3'd5) & dlab) psd <= wr_data;
                    if (ch_wr & (addr[2:1] == 2'b11)) spr <= wr_data;
                    if (load) rhr <= rx_data[8*c +: 8];
                    dr   <= rx_valid[c] | (dr & ~pop);
                    oe   <= (rx_valid[c] & dr & ~pop) | (oe & ~lsr_rd);
                    pe   <= (load & rx_perr[c]) | (pe & ~lsr_rd);
                    fe   <= (load & rx_ferr[c]) | (fe & ~lsr_rd);
                    bi   <= (load & rx_break[c]) | (bi & ~lsr_rd);
                    pm   <= m;
                    dcts <= dm[0] | (dcts & ~msr_rd);
                    ddsr <= dm[1] | (ddsr & ~msr_rd);
                    teri <= (pm[2] & ~m[2]) | (teri & ~msr_rd);
                    dcd  <= dm[3] | (dcd & ~msr_rd);
                    te_prev <= thr_empty[c];
                    thre_p  <= (thr_empty[c] & ~te_prev) | ier_up | (thre_p & ~(thr_hit[c] | thre_clr));
                    pop_r <= pop;
                    thw_r <= thr_hit[c];
                    irq_r <= (ls | rdi | th | ms) & mcr[3];
                end
            end
        end else begin : g_off
            assign rv[8*c +: 8] = 8'h00;
        end
    end
    // registered read port and shared THR data latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            thr_data <= '0;
        end else begin
            rd_valid <= rd_any;
            if (rd_any) rd_data <= rv[8*ch_sel +: 8];
            if (|thr_hit) thr_data <= wr_data;
        end
    end
endmodule

// File: tb/tb_uart_16550_regbank.sv
// tb_uart_16550_regbank: directed vector table plus multi-cycle sequences for the register bank
module tb_uart_16550_regbank;
    localparam int N  = 5;
    localparam int CW = 3;
    logic            clk = 1'b0, rst = 1'b1;
    logic            wr_en = 1'b0, rd_en = 1'b0;
    logic [CW-1:0]   ch_sel = '0;
    logic [2:0]      addr = '0;
    logic [7:0]      wr_data = '0, rd_data, thr_data;
    logic            rd_valid, irq_any;
    logic [N-1:0]    rx_valid = '0, rx_perr = '0, rx_ferr = '0, rx_break = '0;
    logic [N-1:0]    tx_empty = '1, thr_empty = 5'b11101;
    logic [N-1:0]    cts_i = '0, dsr_i = '0, ri_i = '0, cd_i = '0;
    logic [8*N-1:0]  rx_data = '0, lcr_o, mcr_o, fcr_o;
    logic [16*N-1:0] divisor;
    logic [N-1:0]    thr_wr, rx_pop, irq;
    int nvec = 0, nerr = 0;

    uart_16550_regbank #(.NUM_CH(N)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .ch_sel(ch_sel), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_break(rx_break),
        .tx_empty(tx_empty), .thr_empty(thr_empty), .cts_i(cts_i), .dsr_i(dsr_i),
        .ri_i(ri_i), .cd_i(cd_i), .thr_wr(thr_wr), .thr_data(thr_data), .rx_pop(rx_pop),
        .divisor(divisor), .lcr_o(lcr_o), .mcr_o(mcr_o), .fcr_o(fcr_o), .irq(irq),
        .irq_any(irq_any)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] ch;
        logic [2:0] a;
        logic [7:0] d;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int a, input logic [7:0] d);
        wr_en = 1'b1; ch_sel = CW'(ch); addr = 3'(a); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input string name, input int ch, input int a, input logic [7:0] exp);
        rd_en = 1'b1; ch_sel = CW'(ch); addr = 3'(a);
        step();
        rd_en = 1'b0;
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic rx(input int ch, input logic [7:0] d, input logic [2:0] f);
        rx_valid[ch] = 1'b1; rx_data[8*ch +: 8] = d;
        {rx_break[ch], rx_ferr[ch], rx_perr[ch]} = f;
        step();
        rx_valid = '0; rx_perr = '0; rx_ferr = '0; rx_break = '0;
    endtask

    task automatic thr_rise(input int ch);
        thr_empty[ch] = 1'b0;
        step();
        thr_empty[ch] = 1'b1;
        step();
    endtask

    vec_t tbl [27];

    initial begin
        tbl = '{
            '{1'b0, 3'd0, 3'd3, 8'h03}, '{1'b1, 3'd0, 3'd3, 8'h83}, '{1'b0, 3'd0, 3'd0, 8'h01},
            '{1'b0, 3'd0, 3'd1, 8'h00}, '{1'b1, 3'd0, 3'd0, 8'h1B}, '{1'b1, 3'd0, 3'd1, 8'h02},
            '{1'b0, 3'd0, 3'd0, 8'h1B}, '{1'b0, 3'd0, 3'd1, 8'h02}, '{1'b1, 3'd0, 3'd5, 8'hA7},
            '{1'b0, 3'd0, 3'd5, 8'hA7}, '{1'b1, 3'd0, 3'd3, 8'h03}, '{1'b0, 3'd0, 3'd3, 8'h03},
            '{1'b0, 3'd0, 3'd1, 8'h00}, '{1'b0, 3'd0, 3'd5, 8'h60}, '{1'b1, 3'd0, 3'd6, 8'hC3},
            '{1'b0, 3'd0, 3'd7, 8'hC3}, '{1'b1, 3'd4, 3'd7, 8'h3C}, '{1'b0, 3'd4, 3'd7, 8'h3C},
            '{1'b1, 3'd5, 3'd7, 8'hFF}, '{1'b0, 3'd5, 3'd7, 8'h00}, '{1'b0, 3'd0, 3'd7, 8'hC3},
            '{1'b0, 3'd0, 3'd6, 8'h00}, '{1'b0, 3'd0, 3'd2, 8'h01}, '{1'b1, 3'd0, 3'd5, 8'h55},
            '{1'b1, 3'd0, 3'd3, 8'h80}, '{1'b0, 3'd0, 3'd5, 8'hA7}, '{1'b1, 3'd0, 3'd3, 8'h03}
        };
        repeat (3) step();
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        rst = 1'b0;
        step();
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_irq_any", 32'(irq_any), 32'd0);
        check("rst_divisor", 32'(divisor[15:0]), 32'h0001);
        check("rst_lcr", 32'(lcr_o[7:0]), 32'h03);
        check("rst_mcr", 32'(mcr_o[7:0]), 32'h00);
        check("rst_pulses", 32'({thr_wr, rx_pop}), 32'd0);

        for (int i = 0; i < 27; i++) begin
            if (tbl[i].w) wr(int'(tbl[i].ch), int'(tbl[i].a), tbl[i].d);
            else rd($sformatf("vec%0d", i), int'(tbl[i].ch), int'(tbl[i].a), tbl[i].d);
        end
        check("divisor_ch0", 32'(divisor[15:0]), 32'h021B);

        wr(0, 2, 8'h07);
        check("fcr_pulse", 32'(fcr_o[7:0]), 32'h07);
        step();
        check("fcr_selfclr", 32'(fcr_o[7:0]), 32'h01);
        rd("isr_fifo", 0, 2, 8'hC1);
        wr(0, 2, 8'h00);

        wr_en = 1'b1; rd_en = 1'b1; ch_sel = 0; addr = 3'd7; wr_data = 8'h5C;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("wr_rd_dropped", 32'(rd_valid), 32'd0);
        rd("wr_rd_spr", 0, 7, 8'h5C);

        rx(2, 8'h5A, 3'b000);
        rx(2, 8'hA5, 3'b000);
        rd("lsr_ovr", 2, 5, 8'h63);
        rd("rhr_ovr", 2, 0, 8'h5A);
        check("rx_pop_once", 32'(rx_pop), 32'b00100);
        step();
        check("rx_pop_clear", 32'(rx_pop), 32'd0);
        rd("lsr_after", 2, 5, 8'h60);

        wr(1, 1, 8'h07);
        wr(1, 4, 8'h08);
        rx(1, 8'h33, 3'b010);
        rd("isr_ls", 1, 2, 8'h06);
        check("irq1_set", 32'(irq), 32'b00010);
        check("irq_any_set", 32'(irq_any), 32'd1);
        rd("lsr_fe", 1, 5, 8'h49);
        rd("isr_rx", 1, 2, 8'h04);
        rd("rhr_fe", 1, 0, 8'h33);
        rd("isr_none", 1, 2, 8'h01);
        check("irq1_clear", 32'(irq), 32'd0);

        wr(0, 4, 8'h08);
        wr(0, 1, 8'h02);
        rd("isr_thre", 0, 2, 8'h02);
        check("irq0_thre", 32'(irq), 32'b00001);
        rd("isr_thre_clr", 0, 2, 8'h01);
        check("irq0_clear", 32'(irq), 32'd0);
        thr_rise(0);
        rd("isr_thre_again", 0, 2, 8'h02);
        thr_rise(0);
        wr(0, 0, 8'h9E);
        check("thr_wr_pulse", 32'(thr_wr), 32'b00001);
        check("thr_data", 32'(thr_data), 32'h9E);
        step();
        check("thr_wr_clear", 32'(thr_wr), 32'd0);
        rd("isr_thr_wr_clr", 0, 2, 8'h01);

        wr(3, 4, 8'h13);
        wr(3, 1, 8'h08);
        rd("isr_modem", 3, 2, 8'h00);
        check("irq3_gated", 32'(irq[3]), 32'd0);
        rd("msr_loop", 3, 6, 8'h33);
        rd("msr_cleared", 3, 6, 8'h30);
        rd("isr_modem_clr", 3, 2, 8'h01);

        rx(2, 8'h11, 3'b000);
        rx_valid[2] = 1'b1; rx_data[23:16] = 8'h77;
        rd_en = 1'b1; ch_sel = 3'd2; addr = 3'd0;
        step();
        rd_en = 1'b0; rx_valid = '0;
        check("rhr_same_old", 32'(rd_data), 32'h11);
        check("rx_pop_same", 32'(rx_pop), 32'b00100);
        rd("lsr_same", 2, 5, 8'h61);
        rd("rhr_same_new", 2, 0, 8'h77);
        rd("oob_read", N, 0, 8'h00);

        rd_en = 1'b1; ch_sel = 0; addr = 3'd3; rst = 1'b1;
        step();
        rd_en = 1'b0;
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_divisor", 32'(divisor[15:0]), 32'h0001);
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
